// File: rtl/time_set_if.sv
// Button and strobe bundle between the pad-side setting buttons and the time-set controller.
interface time_set_if;
  logic hour_in;
  logic min_in;
  logic sec_in;
  logic al_in;
  logic al_on_off_toggle_in;
  logic hour_inc;
  logic min_inc;
  logic sec_inc;
  logic al_inc;
  logic alarm_enable;
  logic busy;

  modport master (
    output hour_in, min_in, sec_in, al_in, al_on_off_toggle_in,
    input  hour_inc, min_inc, sec_inc, al_inc, alarm_enable, busy
  );

  modport slave (
    input  hour_in, min_in, sec_in, al_in, al_on_off_toggle_in,
    output hour_inc, min_inc, sec_inc, al_inc, alarm_enable, busy
  );
endinterface

// File: rtl/time_set_controller.sv
// Setting-button front end: 2-flop sync, shared debounce, fixed-priority grant,
// single-cycle increment strobes with hold-to-auto-repeat, and the alarm-enable flag.
module time_set_controller #(
  parameter int DEBOUNCE_CYCLES     = 250000,
  parameter int REPEAT_DELAY_CYCLES = 12500000,
  parameter int REPEAT_RATE_CYCLES  = 2500000
) (
  input  logic      clk,
  input  logic      reset_n,
  time_set_if.slave bus
);
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int TMR_W   = $clog2(RPT_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_SAT    = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LOAD   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, WAIT_RELEASE} state_t;

  // Bit order everywhere: {toggle, al, sec, min, hour}; bit 0 has highest priority.
  logic [4:0]       raw;
  logic [4:0]       sync_p0;
  logic [4:0]       sync_p1;
  logic [4:0]       sync_p2;
  logic [DEB_W-1:0] deb_cnt;
  logic [4:0]       deb;

  state_t           state, state_nxt;
  logic [4:0]       grant, grant_nxt;
  logic [3:0]       stb_q, stb_nxt;
  logic             alarm_q, alarm_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             held;

  function automatic logic [4:0] pick_grant(input logic [4:0] req);
    logic [4:0] g;
    g = '0;
    if (req[0])      g[0] = 1'b1;
    else if (req[1]) g[1] = 1'b1;
    else if (req[2]) g[2] = 1'b1;
    else if (req[3]) g[3] = 1'b1;
    else if (req[4]) g[4] = 1'b1;
    return g;
  endfunction

  assign raw = {bus.al_on_off_toggle_in, bus.al_in, bus.sec_in, bus.min_in, bus.hour_in};

  // Synchronizer (p0, p1) and debounce stage; p2 is the copy used to detect change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
      deb_cnt <= '0;
      deb     <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      if (sync_p1 != sync_p2) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_SAT) begin
        deb_cnt <= deb_cnt + DEB_W'(1);
        if (deb_cnt == DEB_LOAD) deb <= sync_p1;
      end
    end
  end

  // Grant/repeat FSM stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      grant   <= '0;
      stb_q   <= '0;
      alarm_q <= 1'b0;
      tmr     <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      stb_q   <= stb_nxt;
      alarm_q <= alarm_nxt;
      tmr     <= tmr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    stb_nxt   = '0;
    alarm_nxt = alarm_q;
    tmr_nxt   = '0;
    held      = |(deb & grant);
    case (state)
      IDLE: begin
        if (deb != '0) begin
          grant_nxt = pick_grant(deb);
          if (grant_nxt[4]) begin
            alarm_nxt = ~alarm_q;
            state_nxt = WAIT_RELEASE;
          end else begin
            stb_nxt   = grant_nxt[3:0];
            state_nxt = DELAY;
          end
        end
      end
      DELAY, REPEAT: begin
        // Release takes precedence, so a strobe due on the same cycle is dropped.
        if (!held) begin
          state_nxt = (deb == '0) ? IDLE : WAIT_RELEASE;
        end else if (tmr == ((state == DELAY) ? DELAY_LAST : RATE_LAST)) begin
          stb_nxt   = grant[3:0];
          state_nxt = REPEAT;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      WAIT_RELEASE: begin
        if (deb == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.hour_inc     = stb_q[0];
  assign bus.min_inc      = stb_q[1];
  assign bus.sec_inc      = stb_q[2];
  assign bus.al_inc       = stb_q[3];
  assign bus.alarm_enable = alarm_q;
  assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with short debounce/repeat parameters.
module tb_time_set_controller;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  time_set_if bus();

  time_set_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_CYCLES(20),
    .REPEAT_RATE_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [3:0] got;
    bus.hour_in = 1'b1;
    #1;
    got = {bus.al_inc, bus.sec_inc, bus.min_inc, bus.hour_inc};
    total++; if (got !== 4'b0000) begin bad++; $display("FAIL reset_stb got=%b want=0000", got); end
    total++; if (bus.alarm_enable !== 1'b0) begin bad++; $display("FAIL reset_alarm got=%b want=0", bus.alarm_enable); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    for (int c = 0; c < 3; c++) begin
      tick();
      got = {bus.al_inc, bus.sec_inc, bus.min_inc, bus.hour_inc};
      total++; if (got !== 4'b0000 || bus.busy !== 1'b0) begin bad++; $display("FAIL reset_hold c=%0d stb=%b busy=%b want 0000/0", c, got, bus.busy); end
    end
    bus.hour_in = 1'b0;
    reset_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      got = {bus.al_inc, bus.sec_inc, bus.min_inc, bus.hour_inc};
      total++; if (got !== 4'b0000 || bus.busy !== 1'b0) begin bad++; $display("FAIL post_reset c=%0d stb=%b busy=%b want 0000/0", c, got, bus.busy); end
    end
  endtask

  task automatic test_single_tap();
    logic [3:0] got, want;
    logic       want_busy;
    bus.min_in = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      tick();
      got       = {bus.al_inc, bus.sec_inc, bus.min_inc, bus.hour_inc};
      want      = (c == 7) ? 4'b0010 : 4'b0000;
      want_busy = (c >= 7 && c <= 16);
      total++; if (got !== want) begin bad++; $display("FAIL tap_stb c=%0d got=%b want=%b", c, got, want); end
      total++; if (bus.busy !== want_busy) begin bad++; $display("FAIL tap_busy c=%0d got=%b want=%b", c, bus.busy, want_busy); end
      bus.min_in = (c + 1 < 10);
    end
  endtask

  task automatic test_hold();
    logic [3:0] got, want;
    logic       want_busy;
    bus.hour_in = 1'b1;
    for (int c = 0; c <= 80; c++) begin
      tick();
      got       = {bus.al_inc, bus.sec_inc, bus.min_inc, bus.hour_inc};
      want      = (c == 7 || (c >= 27 && c <= 59 && (c - 27) % 8 == 0)) ? 4'b0001 : 4'b0000;
      want_busy = (c >= 7 && c <= 66);
      total++; if (got !== want) begin bad++; $display("FAIL hold_stb c=%0d got=%b want=%b", c, got, want); end
      total++; if (bus.busy !== want_busy) begin bad++; $display("FAIL hold_busy c=%0d got=%b want=%b", c, bus.busy, want_busy); end
      bus.hour_in = (c + 1 < 60);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] got;
    bus.sec_in = 1'b1;
    for (int c = 0; c <= 45; c++) begin
      tick();
      got = {bus.al_inc, bus.sec_inc, bus.min_inc, bus.hour_inc};
      total++; if (got !== 4'b0000 || bus.busy !== 1'b0) begin bad++; $display("FAIL bounce c=%0d stb=%b busy=%b want 0000/0", c, got, bus.busy); end
      bus.sec_in = (c + 1 < 30) && (((c + 1) / 2) % 2 == 0);
    end
  endtask

  task automatic test_priority();
    logic [3:0] got, want;
    logic       want_busy;
    bus.hour_in = 1'b1;
    bus.al_in   = 1'b1;
    for (int c = 0; c <= 110; c++) begin
      tick();
      got = {bus.al_inc, bus.sec_inc, bus.min_inc, bus.hour_inc};
      if (c == 7 || c == 27 || c == 35 || c == 43) want = 4'b0001;
      else if (c == 87)                             want = 4'b1000;
      else                                          want = 4'b0000;
      want_busy = (c >= 7 && c <= 66) || (c >= 87 && c <= 96);
      total++; if (got !== want) begin bad++; $display("FAIL prio_stb c=%0d got=%b want=%b", c, got, want); end
      total++; if (bus.busy !== want_busy) begin bad++; $display("FAIL prio_busy c=%0d got=%b want=%b", c, bus.busy, want_busy); end
      bus.hour_in = (c + 1 < 40);
      bus.al_in   = (c + 1 < 60) || (c + 1 >= 80 && c + 1 < 90);
    end
  endtask

  task automatic test_toggle();
    logic [3:0] got;
    logic       want_busy, want_al;
    bus.al_on_off_toggle_in = 1'b1;
    for (int c = 0; c <= 140; c++) begin
      tick();
      got       = {bus.al_inc, bus.sec_inc, bus.min_inc, bus.hour_inc};
      want_al   = (c >= 7 && c <= 76);
      want_busy = (c >= 7 && c <= 56) || (c >= 77 && c <= 126);
      total++; if (got !== 4'b0000) begin bad++; $display("FAIL toggle_stb c=%0d got=%b want=0000", c, got); end
      total++; if (bus.alarm_enable !== want_al) begin bad++; $display("FAIL toggle_alarm c=%0d got=%b want=%b", c, bus.alarm_enable, want_al); end
      total++; if (bus.busy !== want_busy) begin bad++; $display("FAIL toggle_busy c=%0d got=%b want=%b", c, bus.busy, want_busy); end
      bus.al_on_off_toggle_in = (c + 1 < 50) || (c + 1 >= 70 && c + 1 < 120);
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic [3:0] got, want;
    logic       want_busy;
    bus.al_on_off_toggle_in = 1'b1;
    idle_gap(10);
    bus.al_on_off_toggle_in = 1'b0;
    idle_gap(20);
    total++; if (bus.alarm_enable !== 1'b1) begin bad++; $display("FAIL rst_pre_alarm got=%b want=1", bus.alarm_enable); end
    bus.min_in = 1'b1;
    for (int c = 0; c <= 35; c++) begin
      tick();
      got  = {bus.al_inc, bus.sec_inc, bus.min_inc, bus.hour_inc};
      want = (c == 7 || c == 27 || c == 35) ? 4'b0010 : 4'b0000;
      total++; if (got !== want) begin bad++; $display("FAIL rst_pre_stb c=%0d got=%b want=%b", c, got, want); end
    end
    reset_n = 1'b0;
    #1;
    got = {bus.al_inc, bus.sec_inc, bus.min_inc, bus.hour_inc};
    total++; if (got !== 4'b0000) begin bad++; $display("FAIL rst_async_stb got=%b want=0000", got); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b want=0", bus.busy); end
    total++; if (bus.alarm_enable !== 1'b0) begin bad++; $display("FAIL rst_async_alarm got=%b want=0", bus.alarm_enable); end
    for (int c = 0; c < 2; c++) begin
      tick();
      got = {bus.al_inc, bus.sec_inc, bus.min_inc, bus.hour_inc};
      total++; if (got !== 4'b0000 || bus.busy !== 1'b0) begin bad++; $display("FAIL rst_held c=%0d stb=%b busy=%b want 0000/0", c, got, bus.busy); end
    end
    reset_n = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      tick();
      got       = {bus.al_inc, bus.sec_inc, bus.min_inc, bus.hour_inc};
      want      = (c == 7) ? 4'b0010 : 4'b0000;
      want_busy = (c >= 7 && c <= 16);
      total++; if (got !== want) begin bad++; $display("FAIL rst_post_stb c=%0d got=%b want=%b", c, got, want); end
      total++; if (bus.busy !== want_busy) begin bad++; $display("FAIL rst_post_busy c=%0d got=%b want=%b", c, bus.busy, want_busy); end
      total++; if (bus.alarm_enable !== 1'b0) begin bad++; $display("FAIL rst_post_alarm c=%0d got=%b want=0", c, bus.alarm_enable); end
      bus.min_in = (c + 1 < 10);
    end
  endtask

  initial begin
    total                   = 0;
    bad                     = 0;
    reset_n                 = 1'b0;
    bus.hour_in             = 1'b0;
    bus.min_in              = 1'b0;
    bus.sec_in              = 1'b0;
    bus.al_in               = 1'b0;
    bus.al_on_off_toggle_in = 1'b0;
    test_reset();
    test_single_tap();
    idle_gap(20);
    test_hold();
    idle_gap(20);
    test_bounce();
    idle_gap(20);
    test_priority();
    idle_gap(20);
    test_toggle();
    idle_gap(20);
    test_reset_mid_repeat();
    idle_gap(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/time_set_controller.md
# time_set_controller

Front-end controller for the classic VGA clock's setting buttons. It synchronizes and debounces the five raw push-buttons, arbitrates between simultaneous presses with fixed priority, and emits single-cycle increment strobes with hold-to-auto-repeat. It also owns the alarm-enable flag. It sits between the pad inputs and the timekeeping/alarm counters, on the 25 MHz video clock.

## Interface
- DEBOUNCE_CYCLES, 250000: cycles the synchronized button vector must stay constant before it is accepted (10 ms at 25 MHz).
- REPEAT_DELAY_CYCLES, 12500000: cycles from the first strobe to the first auto-repeat strobe (0.5 s).
- REPEAT_RATE_CYCLES, 2500000: cycles between subsequent auto-repeat strobes (0.1 s).
- clk  in  1  video clock; single clock domain.
- reset_n  in  1  reset, asynchronous, active-low.
- hour_in, min_in, sec_in, al_in, al_on_off_toggle_in  in  1 each  raw asynchronous buttons, active-high.
- hour_inc  out  1  one-cycle strobe: increment hours.
- min_inc  out  1  one-cycle strobe: increment minutes.
- sec_inc  out  1  one-cycle strobe: increment seconds.
- al_inc  out  1  one-cycle strobe: increment alarm setting.
- alarm_enable  out  1  level; toggled by al_on_off_toggle_in.
- busy  out  1  high whenever the FSM is not IDLE.

## Operation
- Synchronizer: each raw input passes through 2 flops. The result is the 5-bit vector S = {toggle, al, sec, min, hour}.
- Debounce: one shared counter, width $clog2(DEBOUNCE_CYCLES+1).
  - Cleared on any cycle where S differs from its registered copy.
  - When it reaches DEBOUNCE_CYCLES, the debounced vector D loads S and the counter saturates.
- FSM states: IDLE, DELAY, REPEAT, WAIT_RELEASE.
- IDLE:
  - If D != 0, grant the highest-priority set bit: hour > min > sec > al > toggle.
  - Emit that strobe on the next cycle. For toggle, flip alarm_enable instead; toggle emits no strobe.
  - Go to DELAY for hour/min/sec/al. Go to WAIT_RELEASE for toggle.
- DELAY: the timer counts REPEAT_DELAY_CYCLES.
  - If the granted bit of D drops: go to IDLE if D == 0, else WAIT_RELEASE.
  - On timer expiry: emit one strobe, go to REPEAT.
- REPEAT: emit one strobe every REPEAT_RATE_CYCLES while the granted bit is held. Release is handled as in DELAY.
- WAIT_RELEASE: no strobes. Return to IDLE only once D == 0.
- Other buttons pressed while a grant is active are ignored. They never preempt, and are never queued.
- At most one strobe is asserted in any cycle. Strobes are registered outputs.
- The repeat timer is shared, reloads on every state entry, and is sized $clog2(max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)+1).

## Timing
- Reset values (async assert): all strobes 0, alarm_enable 0, busy 0, D 0, S 0, FSM IDLE, all counters 0.
- Reset deassertion is used synchronously inside the block; the first grant happens no earlier than DEBOUNCE_CYCLES+3 cycles after reset.
- Press latency: a raw rise sampled at edge 0 gives the first strobe high in the cycle after edge DEBOUNCE_CYCLES+3. alarm_enable flips at that same edge.
- Auto-repeat spacing:
  - First strobe to second strobe: exactly REPEAT_DELAY_CYCLES cycles.
  - Thereafter: exactly REPEAT_RATE_CYCLES cycles.
- Release latency: a raw fall stops further strobes within DEBOUNCE_CYCLES+3 cycles. A strobe already scheduled at the same edge that D clears is suppressed.
- Bounce shorter than DEBOUNCE_CYCLES produces no D change and no strobe.
- Simultaneous presses (same debounced update): only the highest-priority strobe fires.
- Reset mid-hold: all outputs clear immediately. A button still held after reset gets a fresh debounce and a fresh first strobe.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=8.
- Single tap: min_in high for 10 cycles → exactly one min_inc pulse, 1 cycle wide, at cycle 7 after the press; busy returns 0 after release debounce.
- Hold: hour_in held 60 cycles → hour_inc strobes at t0, t0+20, t0+28, t0+36, … until release; no strobe after release is debounced.
- Bounce: sec_in toggled every 2 cycles for 30 cycles, then held low → zero sec_inc strobes.
- Priority: hour_in and al_in rise on the same edge and are held 40 cycles → only hour_inc strobes; al_inc stays 0; after hour_in drops with al_in still held → WAIT_RELEASE, no al_inc until both are released and al_in is re-pressed.
- Toggle: al_on_off_toggle_in pressed for 50 cycles, twice → alarm_enable 0→1→0, never auto-repeats; no strobe output is ever asserted.
- Reset mid-repeat: reset_n pulsed low during REPEAT with min_in held → outputs 0 immediately; after deassert, first min_inc at cycle 7, alarm_enable 0.
